// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: word width, divider latency
// default, counter width and the sequencer state encoding.
package hilo_ctrl_pkg;

  localparam int WORD_W      = 32;
  localparam int DIV_LAT_DEF = 34;
  localparam int CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair. A divider capture loads both halves and
// overrides any mthi/mtlo write presented in the same cycle.
module hilo_regs
  import hilo_ctrl_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [DATA_W-1:0] cap_hi,
  input  logic [DATA_W-1:0] cap_lo,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  // Capture first, otherwise independent mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (cap_en) begin
      hi <= cap_hi;
      lo <= cap_lo;
    end else begin
      if (wr_hi) hi <= wr_data;
      if (wr_lo) lo <= wr_data;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// Divide sequencer and HI/LO holder. Accepts a divide request in IDLE,
// registers the operands, pulses the divider start, waits DIV_LAT cycles and
// captures the divider's remainder/quotient into HI/LO. Zero divisors are
// rejected up front with a one-cycle exception pulse.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int DATA_W  = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_div,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div0_exc,
  output logic              div_start,
  output logic [DATA_W-1:0] div_a,
  output logic [DATA_W-1:0] div_b,
  input  logic [DATA_W-1:0] div_high,
  input  logic [DATA_W-1:0] div_low,
  input  logic              div_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic idle;
  logic req_ok;
  logic req_zero;
  logic cap_en;
  logic wr_hi;
  logic wr_lo;

  assign idle     = (state == ST_IDLE);
  assign req_ok   = idle && op_div && (rt_val != '0);
  assign req_zero = idle && op_div && (rt_val == '0);
  assign cap_en   = (state == ST_WAIT) && (cnt == CNT_LAST);

  // A divide request in the same cycle swallows any mthi/mtlo, even when
  // the request itself is rejected for a zero divisor.
  assign wr_hi = idle && !op_div && mthi;
  assign wr_lo = idle && !op_div && mtlo;

  // Sequencer: state, latency counter, operand registers and handshake pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0_exc  <= 1'b0;
      div_start <= 1'b0;
      div_a     <= '0;
      div_b     <= '0;
    end else begin
      done      <= cap_en;
      div0_exc  <= req_zero;
      div_start <= req_ok;
      case (state)
        ST_IDLE: begin
          if (req_ok) begin
            div_a <= rs_val;
            div_b <= rt_val;
            state <= ST_ISSUE;
            busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cap_en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  hilo_regs #(
    .DATA_W (DATA_W)
  ) u_regs (
    .clk     (clk),
    .rst     (rst),
    .cap_en  (cap_en),
    .cap_hi  (div_high),
    .cap_lo  (div_low),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .hi      (hi),
    .lo      (lo)
  );

  // The divisor held in div_b is never zero while waiting, so the divider's
  // zero flag must stay low for the whole WAIT phase.
  a_no_div_zero: assert property (@(posedge clk) disable iff (rst)
                                  (state == ST_WAIT) |-> !div_zero)
    else $error("div_zero raised during WAIT");

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: a latency-accurate divider model, a scoreboard of
// expected done/div0_exc events and HI/LO updates, directed cases and a
// randomized sequence of divides and mthi/mtlo writes.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int LAT = 34;

  logic        clk = 1'b0;
  logic        rst, op_div, mthi, mtlo;
  logic [31:0] rs_val, rt_val, wr_data;
  logic [31:0] hi, lo, div_a, div_b, div_high, div_low;
  logic        busy, done, div0_exc, div_start, div_zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          due;
    bit          exc;
    logic [31:0] hi;
    logic [31:0] lo;
  } evt_t;

  typedef struct {
    int          due;
    bit          set_hi;
    bit          set_lo;
    logic [31:0] val;
  } upd_t;

  evt_t evt_q[$];
  upd_t upd_q[$];

  int          busy_from = -1;
  int          busy_to   = -2;
  int          start_cyc = -1;
  logic [31:0] exp_a = '0, exp_b = '0, exp_hi = '0, exp_lo = '0;

  hilo_ctrl #(.DIV_LAT(LAT), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .op_div(op_div), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div0_exc(div0_exc), .div_start(div_start),
    .div_a(div_a), .div_b(div_b), .div_high(div_high), .div_low(div_low),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: result appears only after LAT cycles, junk before that.
  logic [31:0] dv_a = '0, dv_b = '0;
  int          dv_cnt = 0;
  always @(posedge clk) begin
    if (rst) dv_cnt <= 0;
    else if (div_start) begin
      dv_a   <= div_a;
      dv_b   <= div_b;
      dv_cnt <= 1;
    end else if (dv_cnt > 0 && dv_cnt < 1000) dv_cnt <= dv_cnt + 1;
  end

  always_comb begin
    div_high = 32'hDEAD0001;
    div_low  = 32'hDEAD0002;
    div_zero = 1'b0;
    if (dv_cnt >= LAT) begin
      div_zero = (dv_b == 32'd0);
      if (dv_b != 32'd0) begin
        div_low  = $signed(dv_a) / $signed(dv_b);
        div_high = $signed(dv_a) % $signed(dv_b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: apply scheduled HI/LO updates, pop events on done/div0_exc,
  // and check per-cycle handshake and register state.
  always @(negedge clk) begin
    if (mon_en) begin
      evt_t e;
      while (upd_q.size() > 0 && upd_q[0].due <= cyc) begin
        if (upd_q[0].set_hi) exp_hi = upd_q[0].val;
        if (upd_q[0].set_lo) exp_lo = upd_q[0].val;
        upd_q.delete(0);
      end
      if (evt_q.size() > 0 && evt_q[0].due < cyc) begin
        chk("event_missing", 32'd0, 32'd1);
        evt_q.delete(0);
      end
      if (done || div0_exc) begin
        if (evt_q.size() == 0) begin
          chk("spurious_event", {30'd0, done, div0_exc}, 32'd0);
        end else begin
          e = evt_q.pop_front();
          chk("event_cycle", 32'(cyc), 32'(e.due));
          chk("event_kind_exc", 32'(div0_exc), 32'(e.exc));
          chk("event_kind_done", 32'(done), 32'(!e.exc));
          if (!e.exc) begin
            exp_hi = e.hi;
            exp_lo = e.lo;
          end
        end
      end
      chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
      chk("div_start", 32'(div_start), 32'(cyc == start_cyc));
      if (div_start && cyc == start_cyc) begin
        chk("div_a", div_a, exp_a);
        chk("div_b", div_b, exp_b);
      end
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_div  = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    rs_val  = '0;
    rt_val  = '0;
    wr_data = '0;
  endtask

  // Present a divide request for one cycle; model reacts only if idle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input bit mh, input bit ml, input logic [31:0] wd);
    int   n  = cyc;
    int   ia = a;
    int   ib = b;
    evt_t e;
    op_div = 1'b1; rs_val = a; rt_val = b; mthi = mh; mtlo = ml; wr_data = wd;
    if (n > busy_to) begin
      if (ib == 0) begin
        e.due = n + 1; e.exc = 1'b1; e.hi = '0; e.lo = '0;
        evt_q.push_back(e);
      end else begin
        e.due = n + LAT + 2; e.exc = 1'b0;
        e.lo  = ia / ib;
        e.hi  = ia % ib;
        evt_q.push_back(e);
        busy_from = n + 1;
        busy_to   = n + LAT + 1;
        start_cyc = n + 1;
        exp_a = a;
        exp_b = b;
      end
    end
    tick();
    idle_inputs();
  endtask

  // Present an mthi/mtlo write for one cycle; model reacts only if idle.
  task automatic write(input bit mh, input bit ml, input logic [31:0] wd);
    upd_t u;
    mthi = mh; mtlo = ml; wr_data = wd;
    if (cyc > busy_to) begin
      u.due = cyc + 1; u.set_hi = mh; u.set_lo = ml; u.val = wd;
      upd_q.push_back(u);
    end
    tick();
    idle_inputs();
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc <= busy_to && guard < 200) begin
      tick();
      guard++;
    end
  endtask

  // One-cycle reset in the current cycle; model forgets anything due later.
  task automatic reset_now();
    int   r = cyc;
    upd_t u;
    rst = 1'b1;
    if (busy_to >= r) busy_to = r;
    if (start_cyc > r) start_cyc = -1;
    for (int i = evt_q.size() - 1; i >= 0; i--)
      if (evt_q[i].due > r) evt_q.delete(i);
    for (int i = upd_q.size() - 1; i >= 0; i--)
      if (upd_q[i].due > r) upd_q.delete(i);
    u.due = r + 1; u.set_hi = 1'b1; u.set_lo = 1'b1; u.val = '0;
    upd_q.push_back(u);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, wd;
    int          sel;
    int          n0;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div0_exc", 32'(div0_exc), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_a", div_a, 32'd0);
    chk("rst_div_b", div_b, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // 100 / 7, done 36 cycles after the request
    n0 = cyc;
    issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
    wait_idle();
    chk("t1_done_cycle", 32'(cyc - n0), 32'd36);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_lo", lo, 32'd14);
    chk("t1_hi", hi, 32'd2);

    // -100 / 7, issued in the done cycle of the previous divide
    issue(32'hFFFFFF9C, 32'd7, 1'b0, 1'b0, 32'd0);
    wait_idle();
    chk("t2_lo", lo, 32'hFFFFFFF2);
    chk("t2_hi", hi, 32'hFFFFFFFE);

    // divide by zero with preloaded HI/LO
    tick();
    write(1'b1, 1'b1, 32'hA5A5A5A5);
    issue(32'd5, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("t3_div0_exc", 32'(div0_exc), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("t3_hi", hi, 32'hA5A5A5A5);
    chk("t3_lo", lo, 32'hA5A5A5A5);

    // second request and mthi during WAIT are ignored
    issue(32'd1000, 32'hFFFFFFDF, 1'b0, 1'b0, 32'd0);
    repeat (5) tick();
    issue(32'd7, 32'd3, 1'b0, 1'b0, 32'd0);
    write(1'b1, 1'b0, 32'h00001234);
    wait_idle();
    chk("t4_hi", hi, 32'd10);
    chk("t4_lo", lo, 32'hFFFFFFE2);

    // mthi+mtlo in IDLE, then the same together with op_div
    tick();
    write(1'b1, 1'b1, 32'hDEADBEEF);
    chk("t5_hi", hi, 32'hDEADBEEF);
    chk("t5_lo", lo, 32'hDEADBEEF);
    issue(32'd50, 32'd5, 1'b1, 1'b1, 32'hCAFEF00D);
    chk("t5_hi_dropped", hi, 32'hDEADBEEF);
    wait_idle();
    chk("t5_div_lo", lo, 32'd10);
    issue(32'd9, 32'd0, 1'b1, 1'b1, 32'h11111111);
    tick();
    chk("t5b_lo_kept", lo, 32'd10);

    // reset in cycle 10 of a divide, then a clean divide
    tick();
    n0 = cyc;
    issue(32'd123456, 32'hFFFFFCEB, 1'b0, 1'b0, 32'd0);
    while (cyc < n0 + 10) tick();
    reset_now();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_hi", hi, 32'd0);
    chk("t6_lo", lo, 32'd0);
    chk("t6_div_a", div_a, 32'd0);
    repeat (40) tick();
    issue(32'hFFFFFFB3, 32'hFFFFFFFB, 1'b0, 1'b0, 32'd0);
    wait_idle();
    chk("t6_lo_after", lo, 32'd15);
    chk("t6_hi_after", hi, 32'hFFFFFFFE);

    // randomized mix of divides, writes and ignored pokes while busy
    for (int k = 0; k < 30; k++) begin
      sel = $urandom_range(0, 9);
      a   = $urandom;
      wd  = $urandom;
      if (sel < 6) begin
        if (sel == 0) b = 32'd0;
        else if (sel < 3) b = $urandom_range(1, 9);
        else b = $urandom;
        if ($urandom_range(0, 1) == 1) b = -b;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
        issue(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd);
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(0, 20)) tick();
          if ($urandom_range(0, 1) == 1) issue($urandom, $urandom_range(0, 5), 1'b0, 1'b0, 32'd0);
          else write(1'b1, 1'b1, $urandom);
        end
        if ($urandom_range(0, 3) != 0) wait_idle();
      end else begin
        write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wd);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    repeat (3) tick();
    chk("events_drained", 32'(evt_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
